// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder: packs TP2-subset RV32I fields into 32-bit words with       |
// | sequential byte addresses; one-deep output register with handshakes.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_encoder #(
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_count
);

   localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);
   localparam logic [31:0]       c_nop       = 32'h0000_0013;

   localparam logic [2:0] c_op_lb  = 3'd0;
   localparam logic [2:0] c_op_sb  = 3'd1;
   localparam logic [2:0] c_op_ori = 3'd2;
   localparam logic [2:0] c_op_bne = 3'd3;
   localparam logic [2:0] c_op_add = 3'd4;
   localparam logic [2:0] c_op_and = 3'd5;
   localparam logic [2:0] c_op_sll = 3'd6;

   logic              r_out_valid;
   logic [31:0]       r_out_instr;
   logic [ADDR_W-1:0] r_out_addr;
   logic              r_out_err;
   logic [7:0]        r_err_count;
   logic [ADDR_W-1:0] r_next_addr;

   logic [31:0]       w_instr;
   logic              w_err;
   logic              w_imm_ovf;
   logic              w_accept;

   assign in_ready  = !clear && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   // A 13-bit immediate fits 12 bits only when its top two bits agree.
   assign w_imm_ovf = in_imm[12] ^ in_imm[11];

   always_comb begin
      w_instr = c_nop;
      w_err   = 1'b0;
      case (in_op)
         c_op_lb: begin
            w_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0000011};
            w_err   = w_imm_ovf;
         end
         c_op_sb: begin
            w_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], 7'b0100011};
            w_err   = w_imm_ovf;
         end
         c_op_ori: begin
            w_instr = {in_imm[11:0], in_rs1, 3'b110, in_rd, 7'b0010011};
            w_err   = w_imm_ovf;
         end
         c_op_bne: begin
            w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                       in_imm[4:1], in_imm[11], 7'b1100011};
            w_err   = in_imm[0];
         end
         c_op_add: w_instr = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
         c_op_and: w_instr = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
         c_op_sll: w_instr = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, 7'b0110011};
         default: begin
            w_instr = c_nop;
            w_err   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_addr  <= '0;
         r_out_err   <= 1'b0;
         r_err_count <= '0;
         r_next_addr <= c_base_addr;
      end else if (clear) begin
         r_out_valid <= 1'b0;
         r_err_count <= '0;
         r_next_addr <= c_base_addr;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_instr <= w_instr;
         r_out_addr  <= r_next_addr;
         r_out_err   <= w_err;
         r_next_addr <= r_next_addr + c_addr_step;
         if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_addr  = r_out_addr;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder for the TP2 datapath subset (lb, sb, ori, bne, add, and, sll). It is the inverse of the immediate-extraction path: it packs operation, register and immediate fields back into 32-bit instruction words. It assigns each word a sequential instruction-memory byte address. It sits between the test/program loader and instruction memory, with valid/ready handshakes on both sides.

## Interface
- BASE_ADDR, default 0: byte address assigned to the first word after reset or clear.
- ADDR_W, default 10: width of the address counter. Wraps modulo 2^ADDR_W.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous restart: flush the output, reset the address and error count.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle.
- in_op  in  3  operation: 0 lb, 1 sb, 2 ori, 3 bne, 4 add, 5 and, 6 sll, 7 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  13  signed immediate (two's complement); byte offset for bne.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_err  out  1  encoding error flag for the current word.
- err_count  out  8  saturating count of accepted words with an error.

## Operation
- Accept condition: in_valid && in_ready && !clear. in_ready = !clear && (!out_valid || out_ready), giving a one-deep output register with pass-through when drained.
- I-type encodings:
  - lb: {imm[11:0], rs1, 000, rd, 0000011}
  - ori: {imm[11:0], rs1, 110, rd, 0010011}
- S-type encoding:
  - sb: {imm[11:5], rs2, rs1, 000, imm[4:0], 0100011}
- B-type encoding:
  - bne: {imm[12], imm[10:5], rs2, rs1, 001, imm[4:1], imm[11], 1100011}
- R-type encodings (funct7 = 0000000, opcode 0110011):
  - add: funct3 000
  - sll: funct3 001
  - and: funct3 111
- Fields unused by a format are ignored: in_imm for R-type, rs2 for I-type, rd for S/B-type.
- Errors set out_err=1 for the word:
  - lb/ori/sb: in_imm[12] != in_imm[11] (value does not fit 12 bits). The low 12 bits are still encoded.
  - bne: in_imm[0]=1 (odd offset). Bit 0 is dropped.
  - op 7: out_instr = 0x00000013 (nop).
- Address counter: next_addr register. On accept, out_addr <= next_addr and next_addr <= next_addr + 4, wrapping modulo 2^ADDR_W.
- err_count increments on each accept whose word has an error. It saturates at 255.
- clear, synchronous:
  - out_valid <= 0.
  - next_addr <= BASE_ADDR.
  - err_count <= 0.
  - A bundle presented in the same cycle is not accepted.

## Timing
- Reset values:
  - out_valid 0, out_instr 0, out_addr 0, out_err 0, err_count 0.
  - next_addr BASE_ADDR.
  - in_ready 1 once reset is released.
- Latency 1: a bundle accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: while out_valid && !out_ready:
  - out_instr, out_addr and out_err hold stable.
  - in_ready=0.
  - next_addr does not advance.
- Simultaneous drain and accept in one cycle: the new word replaces the old one. out_valid stays 1.
- Reset mid-stream: all state is cleared immediately (asynchronous). The pending word is lost.
- Wrap: with ADDR_W=10, the word after address 0x3FC gets address 0x000.

## Test plan
- After reset, the bench presents four bundles back to back with out_ready=1. Each must appear one cycle after its accept, at addresses 0, 4, 8, 0xC:
  - lb rd=5 rs1=2 imm=-4 -> 0xFFC10283
  - sb rs1=3 rs2=6 imm=8 -> 0x00618423
  - ori rd=1 rs1=1 imm=240 -> 0x0F00E093
  - bne rs1=1 rs2=2 imm=-8 -> 0xFE209CE3
- R-type: add rd=3 rs1=1 rs2=2 with imm=0x1FFF -> 0x002081B3, out_err=0. and -> 0x0020F1B3. sll -> 0x002091B3.
- Errors:
  - lb imm=2048 -> out_err=1, out_instr=0x80010283.
  - bne imm=3 -> out_err=1, offset encoded as 2.
  - op 7 -> out_err=1, out_instr=0x00000013.
  - err_count reaches 3 after these three.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1. The output must stay stable, in_ready=0, and the address must not advance. After release, addresses must continue contiguously with no word lost or duplicated.
- Boundaries:
  - Encode 256 words: the 257th word gets address 0x000.
  - Generate 300 erroring words: err_count saturates at 255.
  - Assert clear during a stall: out_valid drops and the next word gets BASE_ADDR.
- Asynchronous reset asserted between edges while out_valid=1: outputs go to their reset values before the next edge.
